// File: rtl/fifo2.sv
// rtl/fifo2.sv - single-clock FIFO with occupancy count, thresholds, FWFT mode and sticky error flags
module fifo2 #(
    parameter int W    = 8,
    parameter int L    = 8,
    parameter int AF   = L - 2,
    parameter int AE   = 2,
    parameter int FWFT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 w_en,
    input  logic                 r_en,
    input  logic [W-1:0]         data_in,
    output logic [W-1:0]         data_out,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [$clog2(L):0]   count,
    output logic                 overflow,
    output logic                 underflow
);
    localparam int AW = $clog2(L);
    localparam logic [AW:0] L_C  = L[AW:0];
    localparam logic [AW:0] AF_C = AF[AW:0];
    localparam logic [AW:0] AE_C = AE[AW:0];

    logic [W-1:0] mem [L];
    logic [AW:0]  w_ptr;
    logic [AW:0]  r_ptr;
    logic         rd_acc;
    logic         wr_acc;
    logic         ptr_msb_unused;

    assign full         = (count == L_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    assign rd_acc = r_en & ~empty;
    // A full FIFO still takes a write when the same cycle frees a slot.
    assign wr_acc = w_en & (~full | rd_acc);

    // Occupancy lives in count, so the wrap bits only matter for indexing history.
    assign ptr_msb_unused = w_ptr[AW] ^ r_ptr[AW];

    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[w_ptr[AW-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_ptr     <= '0;
            r_ptr     <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                w_ptr <= w_ptr + 1'b1;
            end
            if (rd_acc) begin
                r_ptr <= r_ptr + 1'b1;
            end
            if (wr_acc && !rd_acc) begin
                count <= count + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                count <= count - 1'b1;
            end
            if (w_en && !wr_acc) begin
                overflow <= 1'b1;
            end
            if (r_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = empty ? '0 : mem[r_ptr[AW-1:0]];
        end else begin : g_reg
            logic [W-1:0] dout_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_q <= '0;
                end else if (rd_acc) begin
                    dout_q <= mem[r_ptr[AW-1:0]];
                end
            end
            assign data_out = dout_q;
        end
    endgenerate
endmodule

// File: tb/tb_fifo2.sv
// tb/tb_fifo2.sv - self-checking bench for fifo2, registered-read and FWFT instances side by side
module tb_fifo2;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       w_en = 1'b0;
    logic       r_en = 1'b0;
    logic [7:0] data_in = 8'h00;

    logic [7:0] dout0, dout1;
    logic       full0, empty0, af0, ae0, ovf0, unf0;
    logic       full1, empty1, af1, ae1, ovf1, unf1;
    logic [3:0] cnt0, cnt1;

    int checks = 0;
    int failures = 0;

    fifo2 #(.W(8), .L(8), .AF(6), .AE(2), .FWFT(0)) u_reg (
        .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .data_in(data_in),
        .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0),
        .almost_empty(ae0), .count(cnt0), .overflow(ovf0), .underflow(unf0)
    );

    fifo2 #(.W(8), .L(8), .AF(6), .AE(2), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .data_in(data_in),
        .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1),
        .almost_empty(ae1), .count(cnt1), .overflow(ovf1), .underflow(unf1)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of words plus the sticky flags.
    logic [7:0] q[$];
    logic [7:0] m_dout0 = 8'h00;
    bit         m_ovf = 1'b0;
    bit         m_unf = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit rs, input bit w, input bit r, input logic [7:0] d);
        bit rd, wa;
        int n;
        logic [7:0] m_dout1;
        rst = rs; w_en = w; r_en = r; data_in = d;
        @(posedge clk);
        #1;
        if (rs) begin
            q.delete();
            m_dout0 = 8'h00;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            rd = r && (q.size() > 0);
            wa = w && ((q.size() < 8) || rd);
            if (w && !wa) m_ovf = 1'b1;
            if (r && q.size() == 0) m_unf = 1'b1;
            if (rd) m_dout0 = q.pop_front();
            if (wa) q.push_back(d);
        end
        n = q.size();
        m_dout1 = (n > 0) ? q[0] : 8'h00;
        chk("count0", 32'(cnt0), 32'(n));
        chk("count1", 32'(cnt1), 32'(n));
        chk("full",   {30'd0, full0, full1},   {30'd0, n == 8, n == 8});
        chk("empty",  {30'd0, empty0, empty1}, {30'd0, n == 0, n == 0});
        chk("afull",  {30'd0, af0, af1},       {30'd0, n >= 6, n >= 6});
        chk("aempty", {30'd0, ae0, ae1},       {30'd0, n <= 2, n <= 2});
        chk("ovf",    {30'd0, ovf0, ovf1},     {30'd0, m_ovf, m_ovf});
        chk("unf",    {30'd0, unf0, unf1},     {30'd0, m_unf, m_unf});
        chk("dout0",  32'(dout0), 32'(m_dout0));
        chk("dout1",  32'(dout1), 32'(m_dout1));
    endtask

    typedef struct {
        bit         rs, w, r;
        logic [7:0] d;
        int         e_count;
        logic [7:0] e_dout;
        bit         e_ovf;
        bit         e_unf;
    } vec_t;

    vec_t tbl[$];

    initial begin
        vec_t v;
        // Table: reset with requests asserted, then fill/overflow/drain three times across wrap.
        for (int i = 0; i < 2; i++) begin
            v = '{1, 1, 1, 8'hFF, 0, 8'h00, 0, 0};
            tbl.push_back(v);
        end
        for (int rep = 0; rep < 3; rep++) begin
            for (int i = 0; i < 8; i++) begin
                v = '{0, 1, 0, 8'(8'h10 + i), i + 1, (rep == 0) ? 8'h00 : 8'h17, rep > 0, 0};
                tbl.push_back(v);
            end
            v = '{0, 1, 0, 8'hEE, 8, (rep == 0) ? 8'h00 : 8'h17, 1, 0};
            tbl.push_back(v);
            for (int i = 0; i < 8; i++) begin
                v = '{0, 0, 1, 8'h00, 7 - i, 8'(8'h10 + i), 1, 0};
                tbl.push_back(v);
            end
        end

        foreach (tbl[i]) begin
            step(tbl[i].rs, tbl[i].w, tbl[i].r, tbl[i].d);
            chk($sformatf("tbl%0d_count", i), 32'(cnt0), 32'(tbl[i].e_count));
            chk($sformatf("tbl%0d_dout", i), 32'(dout0), 32'(tbl[i].e_dout));
            chk($sformatf("tbl%0d_ovf", i), 32'(ovf0), 32'(tbl[i].e_ovf));
            chk($sformatf("tbl%0d_unf", i), 32'(unf0), 32'(tbl[i].e_unf));
        end
        chk("tbl_aempty_end", 32'(ae0), 32'd1);

        // Full pass-through.
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 8'(8'h10 + i));
        step(0, 1, 1, 8'hAA);
        chk("pt_dout", 32'(dout0), 32'h10);
        chk("pt_count", 32'(cnt0), 32'd8);
        chk("pt_full", 32'(full0), 32'd1);
        chk("pt_ovf", 32'(ovf0), 32'd0);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 8'h00);
            chk($sformatf("pt_drain%0d", i), 32'(dout0), (i == 7) ? 32'hAA : 32'(8'h11 + i));
        end
        chk("pt_empty", 32'(empty0), 32'd1);

        // Empty collision: read rejected, write accepted.
        step(0, 1, 1, 8'h55);
        chk("ec_unf", 32'(unf0), 32'd1);
        chk("ec_count", 32'(cnt0), 32'd1);
        chk("ec_dout", 32'(dout0), 32'hAA);
        step(0, 0, 1, 8'h00);
        chk("ec_read", 32'(dout0), 32'h55);

        // FWFT behaviour.
        step(1, 0, 0, 8'h00);
        step(0, 1, 0, 8'h3C);
        chk("fw_head", 32'(dout1), 32'h3C);
        chk("fw_nempty", 32'(empty1), 32'd0);
        step(0, 1, 0, 8'h3D);
        chk("fw_hold", 32'(dout1), 32'h3C);
        step(0, 0, 1, 8'h00);
        chk("fw_pop1", 32'(dout1), 32'h3D);
        step(0, 0, 1, 8'h00);
        chk("fw_pop2", 32'(dout1), 32'h00);
        chk("fw_empty", 32'(empty1), 32'd1);

        // Mid-operation reset.
        for (int i = 0; i < 5; i++) step(0, 1, 0, 8'(8'h60 + i));
        chk("mr_pre", 32'(cnt0), 32'd5);
        step(1, 1, 0, 8'h77);
        chk("mr_count", 32'(cnt0), 32'd0);
        chk("mr_flags", {28'd0, empty0, ae0, af0, full0}, 32'b1100);
        step(0, 1, 0, 8'h99);
        step(0, 0, 1, 8'h00);
        chk("mr_read", 32'(dout0), 32'h99);

        // Randomized traffic with drifting write/read bias and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            int wb;
            wb = ((i / 100) % 2 == 0) ? 70 : 30;
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 99) < wb,
                 $urandom_range(0, 99) < (100 - wb),
                 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
